dma_word_copier: RTL and testbench
==================================

Name: dma_word_copier

Overview:
- Single-channel DMA master that copies a block of 32-bit words from a source address to a destination address.
- Drives the same dmem-style port that memdiv_32 exposes: addr, write data, size, read/write enables, read data, ready, fault.
- Sits directly upstream of memdiv_32's dmem port. When it is busy, the SoC bus mux hands it that port.
- Programmed by the CPU through a small 4-register configuration interface; raises an interrupt pulse on completion.

Parameters:
- LEN_W, 16, width of the word-count register; maximum transfer is 2^LEN_W-1 words.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cfg_we  input  1  config register write strobe
- cfg_addr  input  4  config byte address; bits [3:2] select the register
- cfg_wdata  input  32  config write data
- cfg_rdata  output  32  config read data, combinational from cfg_addr
- irq  output  1  one-cycle pulse on transfer end (done or error)
- busy  output  1  high while a transfer is active; requests the dmem port
- dmem_addr  output  32  memory byte address
- dmem_write_data  output  32  memory write data
- dmem_size  output  2  constant 2'b10 (word)
- dmem_read_en  output  1  memory read request
- dmem_write_en  output  1  memory write request
- dmem_read_data  input  32  read data, valid the cycle after read_en is sampled
- dmem_ready  input  1  memory can accept a request this cycle
- mem_fault  input  1  memory fault, active high

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Registers:
  - 0x0 SRC (32b)
  - 0x4 DST (32b)
  - 0x8 LEN (LEN_W bits, zero-extended on read)
  - 0xC CTRL/STATUS. Write bit0=1 starts a transfer. Read: bit0 busy, bit1 done, bit2 error, bits[31:3]=0.
- Reset values: SRC=DST=LEN=0; done=error=0; state IDLE; irq=0; busy=0; all dmem enables 0; dmem_addr=0; dmem_write_data=0. dmem_size is always 2'b10.
- Register writes while busy: writes to SRC, DST or LEN are ignored; a start write is ignored.
- Start handling: a start write in IDLE clears done and error. The block then checks, on the same edge:
  - SRC[1:0]!=0 or DST[1:0]!=0: set error, pulse irq next cycle, stay IDLE, no memory access.
  - LEN==0: set done, pulse irq next cycle, stay IDLE, no memory access.
  - Otherwise: load working pointers src_p=SRC, dst_p=DST and count=LEN, then go to RD.
- SRC, DST and LEN hold their programmed values. Working copies are separate internal registers.
- State machine IDLE -> RD -> CAP -> WR, looping:
  - RD: dmem_addr=src_p, dmem_read_en=dmem_ready. Advance to CAP only in a cycle where dmem_ready=1; otherwise stall in RD with read_en=0.
  - CAP: latch dmem_read_data into data_buf. No request is issued.
  - WR: dmem_addr=dst_p, dmem_write_data=data_buf, dmem_write_en=dmem_ready. Advance only when dmem_ready=1. On advance: src_p+=4, dst_p+=4, count-=1.
  - After WR: if the new count==0, go to IDLE, set done, and pulse irq for one cycle. Otherwise go to RD.
- Throughput: minimum 3 cycles per word. busy is high in RD, CAP and WR.
- Pointer arithmetic: pointers are 32-bit and wrap modulo 2^32 with no fault. count never underflows.
- Fault: mem_fault=1 sampled in any non-IDLE state aborts the transfer. The block goes to IDLE, sets error, pulses irq and deasserts all enables the following cycle. Any write in flight is the last one issued.
- Simultaneous events: transfer completion and a cfg write to SRC/DST/LEN in the same cycle: the write is ignored, since busy is still high that cycle.
- Reset mid-transfer: all state returns to reset values immediately; no further memory requests are issued.
- dmem_read_en and dmem_write_en are never high in the same cycle. Both are 0 in IDLE and CAP.

Test Plan:
- SRC=0x100, DST=0x200, LEN=4, memory words 0x100..0x10C = A0..A3, start -> words 0x200..0x20C = A0..A3. irq pulses once 12 cycles after the start edge; STATUS=0x2.
- LEN=0, start -> no read_en or write_en; STATUS=0x2; irq pulses next cycle.
- SRC=0x102, start -> STATUS=0x4; no memory access. Then SRC=0x104, restart -> error clears; copy completes with STATUS=0x2.
- LEN=3 with dmem_ready held low for 5 cycles during the second RD -> read_en stays 0 while stalled; data is correct; total time is 9+5 cycles.
- mem_fault pulsed during the second WR of LEN=4 -> STATUS=0x4; only 2 destination words written; busy drops the next cycle.
- Write LEN=9 during an active transfer, and assert rst_n low mid-transfer -> LEN readback unchanged; after reset all registers read 0 and enables stay 0.

Source files
------------

// File: rtl/dma_word_copier.sv
// rtl/dma_word_copier.sv - single-channel DMA word copier on a dmem-style master port
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   cfg_we/addr/wdata    register write strobe, byte address ([3:2] selects), write data
//   cfg_rdata            combinational register read data for cfg_addr
//   irq                  one-cycle pulse when a transfer ends (done or error)
//   busy                 high while copying; requests the shared dmem port
//   dmem_*               memory master port (word-sized requests only)
//   mem_fault            memory fault; aborts an active transfer
//
// Register map: 0x0 SRC, 0x4 DST, 0x8 LEN, 0xC CTRL (wr bit0 start) / STATUS (busy, done, error)
module dma_word_copier #(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        irq,
  output logic        busy,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_write_data,
  output logic [1:0]  dmem_size,
  output logic        dmem_read_en,
  output logic        dmem_write_en,
  input  logic [31:0] dmem_read_data,
  input  logic        dmem_ready,
  input  logic        mem_fault
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CAP  = 2'd2,
    S_WR   = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [31:0]      src_reg, dst_reg;
  logic [LEN_W-1:0] len_reg;
  logic [31:0]      src_p, dst_p;
  logic [LEN_W-1:0] count;
  logic [31:0]      data_buf;
  logic             done, error;
  logic [31:0]      len_ext;

  logic start, misaligned, start_ok, last_word;
  logic unused_cfg_addr;

  assign unused_cfg_addr = ^cfg_addr[1:0];

  assign busy       = (state != S_IDLE);
  assign start      = cfg_we && (cfg_addr[3:2] == 2'b11) && cfg_wdata[0] && !busy;
  assign misaligned = (src_reg[1:0] != 2'b00) || (dst_reg[1:0] != 2'b00);
  assign start_ok   = start && !misaligned && (len_reg != '0);
  assign last_word  = (count == LEN_W'(1));
  assign dmem_size  = 2'b10;

  always_comb begin
    len_ext = '0;
    len_ext[LEN_W-1:0] = len_reg;
    cfg_rdata = '0;
    case (cfg_addr[3:2])
      2'b00:   cfg_rdata = src_reg;
      2'b01:   cfg_rdata = dst_reg;
      2'b10:   cfg_rdata = len_ext;
      default: cfg_rdata = {29'd0, error, done, busy};
    endcase
  end

  // Next state. A fault in any active state wins over normal progress.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start_ok) state_nx = S_RD;
      S_RD: begin
        if (mem_fault)       state_nx = S_IDLE;
        else if (dmem_ready) state_nx = S_CAP;
      end
      S_CAP: begin
        if (mem_fault) state_nx = S_IDLE;
        else           state_nx = S_WR;
      end
      S_WR: begin
        if (mem_fault)       state_nx = S_IDLE;
        else if (dmem_ready) state_nx = last_word ? S_IDLE : S_RD;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Port outputs: requests are gated by ready so a stalled cycle issues nothing.
  always_comb begin
    dmem_addr       = '0;
    dmem_write_data = '0;
    dmem_read_en    = 1'b0;
    dmem_write_en   = 1'b0;
    case (state)
      S_RD: begin
        dmem_addr    = src_p;
        dmem_read_en = dmem_ready;
      end
      S_WR: begin
        dmem_addr       = dst_p;
        dmem_write_data = data_buf;
        dmem_write_en   = dmem_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      src_reg  <= '0;
      dst_reg  <= '0;
      len_reg  <= '0;
      src_p    <= '0;
      dst_p    <= '0;
      count    <= '0;
      data_buf <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      irq      <= 1'b0;
    end else begin
      state <= state_nx;
      irq   <= 1'b0;
      if (state == S_IDLE) begin
        // Programming registers only while idle; the working copies are separate.
        if (cfg_we) begin
          case (cfg_addr[3:2])
            2'b00:   src_reg <= cfg_wdata;
            2'b01:   dst_reg <= cfg_wdata;
            2'b10:   len_reg <= cfg_wdata[LEN_W-1:0];
            default: ;
          endcase
        end
        if (start) begin
          done  <= 1'b0;
          error <= 1'b0;
          if (misaligned) begin
            error <= 1'b1;
            irq   <= 1'b1;
          end else if (len_reg == '0) begin
            done <= 1'b1;
            irq  <= 1'b1;
          end else begin
            src_p <= src_reg;
            dst_p <= dst_reg;
            count <= len_reg;
          end
        end
      end else if (mem_fault) begin
        error <= 1'b1;
        irq   <= 1'b1;
      end else begin
        if (state == S_CAP) data_buf <= dmem_read_data;
        if (state == S_WR && dmem_ready) begin
          src_p <= src_p + 32'd4;
          dst_p <= dst_p + 32'd4;
          count <= count - LEN_W'(1);
          if (last_word) begin
            done <= 1'b1;
            irq  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_word_copier.sv
// tb/tb_dma_word_copier.sv - self-checking bench for dma_word_copier
module tb_dma_word_copier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = 4'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic [31:0] cfg_rdata;
  logic        irq, busy;
  logic [31:0] dmem_addr, dmem_write_data;
  logic [1:0]  dmem_size;
  logic        dmem_read_en, dmem_write_en;
  logic [31:0] dmem_read_data = 32'd0;
  logic        dmem_ready = 1'b1;
  logic        mem_fault = 1'b0;

  always #5 clk = ~clk;

  dma_word_copier #(.LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .irq(irq), .busy(busy),
    .dmem_addr(dmem_addr), .dmem_write_data(dmem_write_data), .dmem_size(dmem_size),
    .dmem_read_en(dmem_read_en), .dmem_write_en(dmem_write_en),
    .dmem_read_data(dmem_read_data), .dmem_ready(dmem_ready), .mem_fault(mem_fault)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: 1024 words, address bits [11:2], read data one cycle later.
  logic [31:0] mem [0:1023];
  logic [31:0] wr_addr_q [$];
  int both_cnt = 0, idle_cnt = 0, stall_bad = 0;

  always @(posedge clk) begin
    if (dmem_read_en && dmem_write_en) both_cnt++;
    if (!busy && (dmem_read_en || dmem_write_en)) idle_cnt++;
    if (dmem_read_en && dmem_ready) dmem_read_data <= mem[dmem_addr[11:2]];
    if (dmem_write_en && dmem_ready) begin
      mem[dmem_addr[11:2]] <= dmem_write_data;
      wr_addr_q.push_back(dmem_addr);
    end
  end

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1 d = cfg_rdata;
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    bit          rnd_ready;
    int          stall_k;   // negedge index where ready drops (-1 none)
    int          stall_n;
    int          fault_k;   // negedge index where mem_fault is raised (-1 none)
    logic [31:0] exp_status;
    int          exp_cycles; // -1: not checked
    int          exp_writes;
  } vec_t;

  // Reference: destination word i must equal the source word i for every
  // completed write, and keep its prior contents otherwise.
  task automatic run_vec(input vec_t v, input int id);
    logic [31:0] srcw [];
    logic [31:0] rd;
    logic [31:0] a;
    int k, bad, badaddr;
    bit got;
    string tag;
    tag = $sformatf("v%0d", id);
    cfg_write(4'h0, v.src);
    cfg_write(4'h4, v.dst);
    cfg_write(4'h8, v.len);
    srcw = new[v.len];
    for (int i = 0; i < v.len; i++) begin
      srcw[i] = $urandom;
      a = v.src + 32'(4 * i);
      mem[a[11:2]] = srcw[i];
    end
    for (int i = 0; i < v.len; i++) begin
      a = v.dst + 32'(4 * i);
      mem[a[11:2]] = 32'hDEAD0000 | 32'(i);
    end
    wr_addr_q.delete();
    cfg_write(4'hC, 32'h1);
    k = 0; got = 0;
    while (k < 2000) begin
      @(negedge clk);
      if (irq) begin got = 1; break; end
      dmem_ready = v.rnd_ready ? 1'($urandom_range(0, 1))
                               : !(k >= v.stall_k && k < v.stall_k + v.stall_n);
      mem_fault = (k == v.fault_k);
      #1 if (!dmem_ready && dmem_read_en) stall_bad++;
      @(posedge clk);
      k++;
    end
    dmem_ready = 1'b1;
    mem_fault  = 1'b0;
    check({tag, "_irq_seen"}, 32'(got), 32'd1);
    check({tag, "_busy_at_irq"}, 32'(busy), 32'd0);
    if (v.exp_cycles >= 0) check({tag, "_cycles"}, 32'(k), 32'(v.exp_cycles));
    cfg_read(4'hC, rd);
    check({tag, "_status"}, rd, v.exp_status);
    check({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(v.exp_writes));
    badaddr = 0;
    foreach (wr_addr_q[i]) if (wr_addr_q[i] !== v.dst + 32'(4 * i)) badaddr++;
    check({tag, "_wr_addr_errs"}, 32'(badaddr), 32'd0);
    bad = 0;
    for (int i = 0; i < v.len; i++) begin
      a = v.dst + 32'(4 * i);
      if (mem[a[11:2]] !== ((i < v.exp_writes) ? srcw[i] : (32'hDEAD0000 | 32'(i)))) bad++;
    end
    check({tag, "_data_errs"}, 32'(bad), 32'd0);
    @(negedge clk);
    check({tag, "_irq_one_cycle"}, 32'(irq), 32'd0);
  endtask

  vec_t vt [$];
  logic [31:0] rd;

  initial begin
    vec_t v;
    vt.push_back('{32'h100, 32'h200, 4, 0, -1, 0, -1, 32'h2, 12, 4});
    vt.push_back('{32'h100, 32'h200, 0, 0, -1, 0, -1, 32'h2,  0, 0});
    vt.push_back('{32'h102, 32'h200, 4, 0, -1, 0, -1, 32'h4,  0, 0});
    vt.push_back('{32'h104, 32'h300, 4, 0, -1, 0, -1, 32'h2, 12, 4});
    vt.push_back('{32'h100, 32'h201, 2, 0, -1, 0, -1, 32'h4,  0, 0});
    vt.push_back('{32'h100, 32'h200, 3, 0,  3, 5, -1, 32'h2, 14, 3});
    vt.push_back('{32'h100, 32'h200, 4, 0, -1, 0,  5, 32'h4,  6, 2});
    vt.push_back('{32'hFFFFFFF8, 32'h400, 4, 0, -1, 0, -1, 32'h2, 12, 4});
    vt.push_back('{32'h010, 32'h800, 7, 1, -1, 0, -1, 32'h2, -1, 7});

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_en", {30'd0, dmem_read_en, dmem_write_en}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_write_data, 32'd0);
    check("rst_size", 32'(dmem_size), 32'd2);
    for (int r = 0; r < 4; r++) begin
      cfg_read(4'(r * 4), rd);
      check($sformatf("rst_reg%0d", r), rd, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) run_vec(vt[i], i);

    for (int i = 0; i < 6; i++) begin
      v.len        = $urandom_range(1, 16);
      v.src        = 32'($urandom_range(0, 127) * 4);
      v.dst        = 32'h800 + 32'($urandom_range(0, 127) * 4);
      v.rnd_ready  = 1;
      v.stall_k    = -1; v.stall_n = 0; v.fault_k = -1;
      v.exp_status = 32'h2; v.exp_cycles = -1; v.exp_writes = v.len;
      run_vec(v, 100 + i);
    end

    // LEN write landing on the completion edge is ignored.
    cfg_write(4'h0, 32'h100);
    cfg_write(4'h4, 32'h200);
    cfg_write(4'h8, 32'd1);
    cfg_write(4'hC, 32'h1);
    repeat (2) @(posedge clk);
    cfg_write(4'h8, 32'd5);
    @(negedge clk);
    cfg_read(4'h8, rd);
    check("len_on_done_edge", rd, 32'd1);
    cfg_read(4'hC, rd);
    check("status_len1", rd, 32'h2);

    // Writes while busy are ignored, then reset mid-transfer.
    cfg_write(4'h8, 32'd4);
    cfg_write(4'hC, 32'h1);
    repeat (2) @(posedge clk);
    cfg_write(4'h8, 32'd9);
    cfg_write(4'h0, 32'h40);
    @(negedge clk);
    cfg_read(4'h8, rd);
    check("len_busy_write", rd, 32'd4);
    cfg_read(4'h0, rd);
    check("src_busy_write", rd, 32'h100);
    check("busy_mid", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_en", {30'd0, dmem_read_en, dmem_write_en}, 32'd0);
    check("midrst_addr", dmem_addr, 32'd0);
    for (int r = 0; r < 4; r++) begin
      cfg_read(4'(r * 4), rd);
      check($sformatf("midrst_reg%0d", r), rd, 32'd0);
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_en", {30'd0, dmem_read_en, dmem_write_en}, 32'd0);

    check("rd_wr_overlap_cycles", 32'(both_cnt), 32'd0);
    check("idle_request_cycles", 32'(idle_cnt), 32'd0);
    check("stalled_read_en_cycles", 32'(stall_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
